// File: rtl/dma_bus_arbiter.sv
// Round-robin arbiter sharing the Z80 bus-master slot between up to four DMA masters.
// Optional DMA_ARB_KEEPBUS_EN keeps the bus across back-to-back masters via a HANDOVER cycle.
module dma_bus_arbiter #(
  parameter int NREQ    = 2,
  parameter int CPU_GAP = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req,
  output logic [NREQ-1:0]      m_busak_n,
  input  logic [16*NREQ-1:0]   m_a,
  input  logic [8*NREQ-1:0]    m_dout,
  input  logic [NREQ-1:0]      m_mreq_n,
  input  logic [NREQ-1:0]      m_iorq_n,
  input  logic [NREQ-1:0]      m_rd_n,
  input  logic [NREQ-1:0]      m_wr_n,
  output logic                 busrq_n,
  input  logic                 busak_n,
  output logic [15:0]          bus_a,
  output logic [7:0]           bus_dout,
  output logic                 bus_mreq_n,
  output logic                 bus_iorq_n,
  output logic                 bus_rd_n,
  output logic                 bus_wr_n
);

`ifdef DMA_ARB_KEEPBUS_EN
  typedef enum logic [2:0] {IDLE, REQ, GRANT, RELEASE, GAP, HANDOVER} state_t;
`else
  typedef enum logic [2:0] {IDLE, REQ, GRANT, RELEASE, GAP} state_t;
`endif

  localparam logic [2:0] GAP_MAX  = 3'(CPU_GAP);
  localparam logic [2:0] GAP_LAST = 3'((CPU_GAP > 0) ? CPU_GAP - 1 : 0);

  state_t      state;
  logic [1:0]  owner;
  logic [1:0]  last;
  logic [2:0]  gapcnt;
  logic [3:0]  busak_q;
  logic        bus_en;

  // Masters padded to four slots so owner can index directly; absent slots look idle.
  logic [3:0]  req_w, mreq_w, iorq_w, rd_w, wr_w;
  logic [15:0] a_arr [4];
  logic [7:0]  d_arr [4];
  logic        any_req;

  for (genvar i = 0; i < 4; i++) begin : g_pad
    if (i < NREQ) begin : g_real
      assign req_w[i]  = req[i];
      assign mreq_w[i] = m_mreq_n[i];
      assign iorq_w[i] = m_iorq_n[i];
      assign rd_w[i]   = m_rd_n[i];
      assign wr_w[i]   = m_wr_n[i];
      assign a_arr[i]  = m_a[16*i +: 16];
      assign d_arr[i]  = m_dout[8*i +: 8];
    end else begin : g_absent
      assign req_w[i]  = 1'b0;
      assign mreq_w[i] = 1'b1;
      assign iorq_w[i] = 1'b1;
      assign rd_w[i]   = 1'b1;
      assign wr_w[i]   = 1'b1;
      assign a_arr[i]  = 16'h0000;
      assign d_arr[i]  = 8'h00;
    end
  end

  assign any_req = |req_w;

  function automatic logic [1:0] rr_pick(input logic [3:0] r, input logic [1:0] from);
    logic [1:0] w;
    logic       found;
    int         idx;
    w     = from;
    found = 1'b0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = (int'(from) + k) % NREQ;
      if (!found && r[2'(idx)]) begin
        w     = 2'(idx);
        found = 1'b1;
      end
    end
    return w;
  endfunction

  function automatic logic [3:0] grant_n(input logic [1:0] o);
    logic [3:0] g;
    g    = 4'b1111;
    g[o] = 1'b0;
    return g;
  endfunction

  function automatic logic [2:0] sat_inc(input logic [2:0] c);
    return (c >= GAP_MAX) ? c : c + 3'd1;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      owner   <= 2'd0;
      last    <= 2'(NREQ - 1);
      gapcnt  <= 3'd0;
      busrq_n <= 1'b1;
      busak_q <= 4'b1111;
      bus_en  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            busrq_n <= 1'b0;
            state   <= REQ;
          end
        end
        REQ: begin
          if (!busak_n) begin
            if (any_req) begin
              owner   <= rr_pick(req_w, last);
              busak_q <= grant_n(rr_pick(req_w, last));
              bus_en  <= 1'b1;
              state   <= GRANT;
            end else begin
              busrq_n <= 1'b1;
              state   <= RELEASE;
            end
          end
        end
        GRANT: begin
          // A CPU that takes the bus back wins over the owner.
          if (busak_n) begin
            last    <= owner;
            busak_q <= 4'b1111;
            bus_en  <= 1'b0;
            busrq_n <= 1'b1;
            state   <= RELEASE;
          end else if (!req_w[owner]) begin
            last    <= owner;
            busak_q <= 4'b1111;
            bus_en  <= 1'b0;
`ifdef DMA_ARB_KEEPBUS_EN
            if (any_req) begin
              state <= HANDOVER;
            end else begin
              busrq_n <= 1'b1;
              state   <= RELEASE;
            end
`else
            busrq_n <= 1'b1;
            state   <= RELEASE;
`endif
          end
        end
        RELEASE: begin
          if (busak_n) begin
            gapcnt <= 3'd0;
            if (CPU_GAP == 0) state <= IDLE;
            else              state <= GAP;
          end
        end
        GAP: begin
          gapcnt <= sat_inc(gapcnt);
          if (gapcnt == GAP_LAST) state <= IDLE;
        end
`ifdef DMA_ARB_KEEPBUS_EN
        HANDOVER: begin
          if (busak_n || !any_req) begin
            busrq_n <= 1'b1;
            state   <= RELEASE;
          end else begin
            owner   <= rr_pick(req_w, last);
            busak_q <= grant_n(rr_pick(req_w, last));
            bus_en  <= 1'b1;
            state   <= GRANT;
          end
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end

  assign m_busak_n  = busak_q[NREQ-1:0];
  assign bus_a      = bus_en ? a_arr[owner]  : 16'h0000;
  assign bus_dout   = bus_en ? d_arr[owner]  : 8'h00;
  assign bus_mreq_n = bus_en ? mreq_w[owner] : 1'b1;
  assign bus_iorq_n = bus_en ? iorq_w[owner] : 1'b1;
  assign bus_rd_n   = bus_en ? rd_w[owner]   : 1'b1;
  assign bus_wr_n   = bus_en ? wr_w[owner]   : 1'b1;

endmodule

// File: tb/tb_dma_bus_arbiter.sv
// Directed bench for dma_bus_arbiter (NREQ=2, CPU_GAP=4); honours DMA_ARB_KEEPBUS_EN when defined.
module tb_dma_bus_arbiter;
  logic        clk;
  logic        rst;
  logic [1:0]  req;
  logic [1:0]  m_busak_n;
  logic [31:0] m_a;
  logic [15:0] m_dout;
  logic [1:0]  m_mreq_n, m_iorq_n, m_rd_n, m_wr_n;
  logic        busrq_n;
  logic        busak_n;
  logic [15:0] bus_a;
  logic [7:0]  bus_dout;
  logic        bus_mreq_n, bus_iorq_n, bus_rd_n, bus_wr_n;

  int n_vec = 0;
  int n_err = 0;
  int cnt;

  dma_bus_arbiter #(.NREQ(2), .CPU_GAP(4)) dut (
    .clk(clk), .rst(rst), .req(req), .m_busak_n(m_busak_n),
    .m_a(m_a), .m_dout(m_dout),
    .m_mreq_n(m_mreq_n), .m_iorq_n(m_iorq_n), .m_rd_n(m_rd_n), .m_wr_n(m_wr_n),
    .busrq_n(busrq_n), .busak_n(busak_n),
    .bus_a(bus_a), .bus_dout(bus_dout),
    .bus_mreq_n(bus_mreq_n), .bus_iorq_n(bus_iorq_n),
    .bus_rd_n(bus_rd_n), .bus_wr_n(bus_wr_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; req = 2'b11; busak_n = 1'b1;
    m_a = {16'h8000, 16'h0000}; m_dout = 16'h0000;
    m_mreq_n = 2'b11; m_iorq_n = 2'b11; m_rd_n = 2'b11; m_wr_n = 2'b11;
    tick; tick;
    chk("rst_busrq_n", 32'(busrq_n), 32'h1);
    chk("rst_m_busak_n", 32'(m_busak_n), 32'h3);
    chk("rst_strobes", 32'({bus_mreq_n, bus_iorq_n, bus_rd_n, bus_wr_n}), 32'hf);
    chk("rst_bus_a", 32'(bus_a), 32'h0);
    chk("rst_bus_dout", 32'(bus_dout), 32'h0);

    rst = 1'b0;
    tick;
    chk("req_busrq_n", 32'(busrq_n), 32'h0);
    chk("req_no_grant", 32'(m_busak_n), 32'h3);
    busak_n = 1'b0;
    tick;
    chk("grant0_m_busak_n", 32'(m_busak_n), 32'h2);
    chk("grant0_busrq_n", 32'(busrq_n), 32'h0);

    // master 0 writes, master 1 drives a read that must be ignored
    m_a[15:0] = 16'h4000; m_dout[7:0] = 8'ha5;
    m_mreq_n = 2'b00; m_wr_n = 2'b10; m_rd_n = 2'b01;
    #1;
    chk("mux_bus_a", 32'(bus_a), 32'h4000);
    chk("mux_bus_dout", 32'(bus_dout), 32'ha5);
    chk("mux_mreq_n", 32'(bus_mreq_n), 32'h0);
    chk("mux_wr_n", 32'(bus_wr_n), 32'h0);
    chk("mux_rd_n", 32'(bus_rd_n), 32'h1);
    chk("mux_iorq_n", 32'(bus_iorq_n), 32'h1);

    // master 0 drops req with its strobes still low
    req = 2'b10;
    tick;
    chk("drop_m_busak_n", 32'(m_busak_n), 32'h3);
    chk("drop_bus_wr_n", 32'(bus_wr_n), 32'h1);
    chk("drop_bus_a", 32'(bus_a), 32'h0);
`ifdef DMA_ARB_KEEPBUS_EN
    chk("handover_busrq_n", 32'(busrq_n), 32'h0);
    chk("handover_mreq_n", 32'(bus_mreq_n), 32'h1);
    m_mreq_n[0] = 1'b1; m_wr_n[0] = 1'b1;
    tick;
    chk("handover_grant1", 32'(m_busak_n), 32'h1);
    chk("handover_busrq_n2", 32'(busrq_n), 32'h0);
    #1;
    chk("handover_bus_a", 32'(bus_a), 32'h8000);
    m_rd_n[1] = 1'b1; m_wr_n[1] = 1'b0;
    #1;
    chk("pre_rst_wr_n", 32'(bus_wr_n), 32'h0);
`else
    chk("drop_busrq_n", 32'(busrq_n), 32'h1);
    m_mreq_n[0] = 1'b1; m_wr_n[0] = 1'b1;
    busak_n = 1'b1;
    req = 2'b11;
    tick;
    cnt = 0;
    while (busrq_n && cnt < 20) begin
      cnt++;
      tick;
    end
    chk("cpu_gap_cycles", 32'(cnt), 32'd5);
    busak_n = 1'b0;
    tick;
    chk("rr_grant1", 32'(m_busak_n), 32'h1);
    #1;
    chk("rr_bus_a", 32'(bus_a), 32'h8000);
    chk("rr_rd_n", 32'(bus_rd_n), 32'h0);

    // CPU takes the bus back while master 1 owns it
    busak_n = 1'b1;
    tick;
    chk("cpu_abort_m_busak_n", 32'(m_busak_n), 32'h3);
    chk("cpu_abort_busrq_n", 32'(busrq_n), 32'h1);
    cnt = 0;
    while (busrq_n && cnt < 20) begin
      cnt++;
      tick;
    end
    chk("rerequest_in_time", 32'(busrq_n), 32'h0);
    busak_n = 1'b0;
    tick;
    chk("rr_grant0", 32'(m_busak_n), 32'h2);
    m_wr_n[0] = 1'b0;
    #1;
    chk("pre_rst_wr_n", 32'(bus_wr_n), 32'h0);
`endif

    // asynchronous reset in the middle of a write
    #1 rst = 1'b1;
    #1;
    chk("async_rst_busrq_n", 32'(busrq_n), 32'h1);
    chk("async_rst_wr_n", 32'(bus_wr_n), 32'h1);
    chk("async_rst_m_busak_n", 32'(m_busak_n), 32'h3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
